// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and the queued-entry bundle for the UART Rx path.
// Holds one-hot Rx state codes, enable levels, data width and the FIFO entry layout.
package uart_rx_pkg;

  localparam logic [4:0] INTERVAL  = 5'b00001;
  localparam logic [4:0] STARTBIT  = 5'b00010;
  localparam logic [4:0] DATABITS  = 5'b00100;
  localparam logic [4:0] PARITYBIT = 5'b01000;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int DATA_BITS = 8;

  typedef struct packed {
    logic                 perr;
    logic [DATA_BITS-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte queue with a registered head entry.
// Ports: clk, rst, push/din in; ready in; dout/valid/full/level/overflow out.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [8:0]                din,
  input  logic                      ready,
  output logic [8:0]                dout,
  output logic                      valid,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] rd_r;
  logic [AW-1:0] wr_r;
  logic [AW-1:0] rd_inc;
  logic [LW-1:0] cnt_r;
  logic [LW-1:0] cnt_nxt;
  logic [8:0]    head_r;
  logic [8:0]    head_nxt;
  logic          pop;
  logic          wr_en;
  logic          empty;

  assign empty    = (cnt_r == '0);
  assign full     = (cnt_r == LW'(DEPTH));
  assign pop      = ready & ~empty;
  // A full queue still accepts a push when the head leaves this cycle.
  assign wr_en    = push & (~full | pop);
  assign overflow = push & full & ~pop;
  assign rd_inc   = rd_r + AW'(1);

  always_comb begin
    cnt_nxt = cnt_r;
    unique case ({wr_en, pop})
      2'b10:   cnt_nxt = cnt_r + LW'(1);
      2'b01:   cnt_nxt = cnt_r - LW'(1);
      default: cnt_nxt = cnt_r;
    endcase
  end

  // Head register tracks the entry that will be at rd after this edge.
  always_comb begin
    head_nxt = head_r;
    if (empty) begin
      if (wr_en) head_nxt = din;
    end else if (pop) begin
      if (cnt_r == LW'(1)) begin
        if (wr_en) head_nxt = din;
      end else begin
        head_nxt = mem[rd_inc];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_r] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_r   <= '0;
      wr_r   <= '0;
      cnt_r  <= '0;
      head_r <= '0;
    end else begin
      if (wr_en) wr_r <= wr_r + AW'(1);
      if (pop)   rd_r <= rd_inc;
      cnt_r  <= cnt_nxt;
      head_r <= head_nxt;
    end
  end

  assign dout  = head_r;
  assign valid = ~empty;
  assign level = cnt_r;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: assembles Rx bytes, checks parity, queues them, runs a stall watchdog.
// Ports: Rx state/bit strobes and config in; head byte, level, sticky flags, Recover_o out.
module uart_rx_frame_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int WD_LIMIT   = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          p_Enable_i,
  input  logic [4:0]                    State_i,
  input  logic [3:0]                    BitCounter_i,
  input  logic                          Bit_Synch_i,
  input  logic                          BitValue_i,
  input  logic                          p_ParityEnable_i,
  input  logic                          p_ParityOdd_i,
  input  logic                          Ready_i,
  input  logic                          ClearErr_i,
  output logic [7:0]                    Data_o,
  output logic                          ParityErr_o,
  output logic                          Valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   Level_o,
  output logic                          Overrun_o,
  output logic                          Timeout_o,
  output logic                          Recover_o
);

  import uart_rx_pkg::*;

  localparam int WW = (WD_LIMIT > 2) ? $clog2(WD_LIMIT) : 1;

  logic                 en;
  logic                 in_start;
  logic                 in_data;
  logic                 in_par;
  logic                 bit_data;
  logic                 commit_np;
  logic                 commit_p;
  logic                 commit;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] byte_nxt;
  logic                 acc_r;
  logic                 perr;
  logic [WW-1:0]        wd_r;
  logic                 wd_inc;
  logic                 wd_fire;
  logic                 ovf;
  logic                 full;
  rx_entry_t            ent;
  logic [8:0]           head;

  assign en       = (p_Enable_i == ENABLE);
  assign in_start = (State_i == STARTBIT);
  assign in_data  = (State_i == DATABITS);
  assign in_par   = (State_i == PARITYBIT);

  assign bit_data  = en & Bit_Synch_i & in_data;
  assign commit_np = bit_data & ~p_ParityEnable_i
                   & (BitCounter_i == 4'd7);
  assign commit_p  = en & Bit_Synch_i & in_par
                   & p_ParityEnable_i;
  assign commit    = commit_np | commit_p;

  // Byte including the bit landing this cycle, so a
  // parity-less commit sees all eight bits.
  always_comb begin
    byte_nxt = shift_r;
    if (!BitCounter_i[3]) byte_nxt[BitCounter_i[2:0]] = BitValue_i;
  end

  assign perr = ((acc_r ^ BitValue_i) != p_ParityOdd_i);

  always_comb begin
    ent = '0;
    if (commit_p) begin
      ent.perr = perr;
      ent.data = shift_r;
    end else begin
      ent.perr = 1'b0;
      ent.data = byte_nxt;
    end
  end

  // Any non-INTERVAL code, including illegal ones, counts as stalled.
  assign wd_inc  = en & (State_i != INTERVAL) & ~Bit_Synch_i;
  assign wd_fire = wd_inc & (wd_r == WW'(WD_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= '0;
      acc_r   <= 1'b0;
    end else if (!en || wd_fire || commit || in_start) begin
      shift_r <= '0;
      acc_r   <= 1'b0;
    end else if (bit_data) begin
      shift_r <= byte_nxt;
      acc_r   <= acc_r ^ BitValue_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_r <= '0;
    end else if (!wd_inc || wd_fire) begin
      wd_r <= '0;
    end else begin
      wd_r <= wd_r + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Recover_o <= 1'b0;
      Timeout_o <= 1'b0;
      Overrun_o <= 1'b0;
    end else begin
      Recover_o <= wd_fire;
      if (wd_fire)         Timeout_o <= 1'b1;
      else if (ClearErr_i) Timeout_o <= 1'b0;
      if (ovf)             Overrun_o <= 1'b1;
      else if (ClearErr_i) Overrun_o <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (commit),
    .din      (ent),
    .ready    (Ready_i),
    .dout     (head),
    .valid    (Valid_o),
    .full     (full),
    .level    (Level_o),
    .overflow (ovf)
  );

  assign Data_o      = head[7:0];
  assign ParityErr_o = head[8];

endmodule
